// File: rtl/pulse_cnt_pkg.sv
// Shared types, default constants and the saturating-add helper for the
// pulse event counter.
//   out_state_t : output handshake FSM states (IDLE, HOLD)
//   FILT_DEF, WIDTH_DEF, WINDOW_DEF : default parameter values
//   sat_inc()   : value + inc, clamped to 2^width - 1 (width 1..32)
package pulse_cnt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } out_state_t;

  localparam int FILT_DEF   = 3;
  localparam int WIDTH_DEF  = 8;
  localparam int WINDOW_DEF = 100;

  // Saturating add. The sum is formed one bit wider so that a carry out
  // of a full 32-bit value is still seen as exceeding the limit.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] inc,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] lim;
    lim = (33'd1 << width) - 33'd1;
    sum = {1'b0, value} + {1'b0, inc};
    if (sum > lim) begin
      sat_inc = lim[31:0];
    end else begin
      sat_inc = sum[31:0];
    end
  endfunction

endpackage

// File: rtl/pulse_event_counter_glitch_filter.sv
// Two-flop synchroniser followed by a persistence filter: the filtered level
// only follows the synchronised input once it has disagreed with the current
// level for FILT consecutive clock edges. Reusable for any asynchronous input.
// Ports:
//   i_clk        : clock
//   i_rst        : synchronous active-high reset
//   i_d_async    : raw asynchronous input
//   o_level      : filtered level (registered)
//   o_level_next : value o_level takes at the next edge (for edge detection)
module glitch_filter #(
  parameter int FILT = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d_async,
  output logic o_level,
  output logic o_level_next
);

  logic       r_s1;
  logic       r_s2;
  logic       r_level;
  logic [3:0] r_fc;
  logic       w_expire;

  // The current edge is the FILT-th consecutive one on which s2 disagrees.
  assign w_expire     = (r_s2 != r_level) && (r_fc == 4'(FILT - 1));
  assign o_level_next = w_expire ? r_s2 : r_level;
  assign o_level      = r_level;

  // Synchroniser, disagreement counter and filtered level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_fc    <= 4'd0;
    end else begin
      r_s1 <= i_d_async;
      r_s2 <= r_s1;
      if (r_s2 == r_level) begin
        r_fc <= 4'd0;
      end else if (w_expire) begin
        r_level <= r_s2;
        r_fc    <= 4'd0;
      end else begin
        r_fc <= r_fc + 4'd1;
      end
    end
  end

endmodule

// File: rtl/pulse_event_counter.sv
// Counts clean rising edges of an asynchronous, possibly glitchy pulse input
// over fixed windows of WINDOW cycles and hands each window's count to the
// next stage over valid/ready. A snapshot that arrives while the previous one
// is still unaccepted is dropped and flagged on the sticky overrun output.
// Ports:
//   i_clk       : clock
//   i_rst       : synchronous active-high reset
//   i_sig_in    : raw asynchronous pulse input
//   o_level     : filtered, synchronised level of i_sig_in
//   o_cnt_out   : rising-edge count of the last completed window
//   o_cnt_valid : o_cnt_out holds an untransferred snapshot
//   i_cnt_ready : consumer accepts o_cnt_out
//   o_overrun   : sticky, a snapshot was dropped
module pulse_event_counter
  import pulse_cnt_pkg::*;
#(
  parameter int FILT   = FILT_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sig_in,
  output logic             o_level,
  output logic [WIDTH-1:0] o_cnt_out,
  output logic             o_cnt_valid,
  input  logic             i_cnt_ready,
  output logic             o_overrun
);

  localparam int WCW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic             w_level;
  logic             w_level_next;
  logic             w_rise;
  logic             w_win_end;
  logic [WIDTH-1:0] w_snapshot;

  logic [WCW-1:0]   r_wcnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_cnt_out;
  logic             r_cnt_valid;
  logic             r_overrun;
  out_state_t       r_state;

  glitch_filter #(
    .FILT(FILT)
  ) u_filter (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_d_async   (i_sig_in),
    .o_level     (w_level),
    .o_level_next(w_level_next)
  );

  // Rise is flagged in the cycle the level is about to go high, so a rise on
  // the window's last edge is still counted in the closing window.
  assign w_rise     = w_level_next & ~w_level;
  assign w_win_end  = (r_wcnt == WCW'(WINDOW - 1));
  assign w_snapshot = WIDTH'(sat_inc(32'(r_acc), {31'd0, w_rise}, WIDTH));

  // Window timer and saturating accumulator.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wcnt <= {WCW{1'b0}};
      r_acc  <= {WIDTH{1'b0}};
    end else begin
      if (w_win_end) begin
        r_wcnt <= {WCW{1'b0}};
        r_acc  <= {WIDTH{1'b0}};
      end else begin
        r_wcnt <= r_wcnt + WCW'(1);
        r_acc  <= w_snapshot;
      end
    end
  end

  // Output handshake FSM with registered count, valid and sticky overrun.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt_out   <= {WIDTH{1'b0}};
      r_cnt_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_win_end) begin
            r_cnt_out   <= w_snapshot;
            r_cnt_valid <= 1'b1;
            r_state     <= HOLD;
          end else begin
            r_cnt_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (i_cnt_ready && !w_win_end) begin
            r_cnt_valid <= 1'b0;
            r_state     <= IDLE;
          end else if (i_cnt_ready) begin
            // Transfer and new snapshot coincide: reload and stay valid.
            r_cnt_out <= w_snapshot;
          end else if (w_win_end) begin
            r_overrun <= 1'b1;
          end else begin
            r_cnt_valid <= 1'b1;
          end
        end
        default: begin
          r_cnt_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign o_level     = w_level;
  assign o_cnt_out   = r_cnt_out;
  assign o_cnt_valid = r_cnt_valid;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_pulse_event_counter.sv
// Self-checking bench for pulse_event_counter. Two instances share clock and
// reset: u_dut with default parameters and u_sat (FILT=1, WIDTH=4) for the
// saturation scenario. A behavioural model keeps the raw input history per
// edge and derives level, window counts and handshake state from the rules.
module tb_pulse_event_counter;

  localparam int F0 = 3, W0 = 8, WIN0 = 100;
  localparam int F1 = 1, W1 = 4, WIN1 = 100;

  logic clk, rst;
  logic sig0, rdy0, sig1, rdy1;
  logic lvl0, val0, ovr0, lvl1, val1, ovr1;
  logic [7:0] cnt0;
  logic [3:0] cnt1;

  int total = 0;
  int bad   = 0;

  // model state, index 0 = u_dut, 1 = u_sat
  bit raw_h [2][64];
  int m_n [2];
  bit m_lvl [2];
  int m_rises [2];
  bit m_pend [2];
  int m_val [2];
  bit m_ovr [2];

  pulse_event_counter #(.FILT(F0), .WIDTH(W0), .WINDOW(WIN0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_sig_in(sig0), .o_level(lvl0),
    .o_cnt_out(cnt0), .o_cnt_valid(val0), .i_cnt_ready(rdy0), .o_overrun(ovr0));

  pulse_event_counter #(.FILT(F1), .WIDTH(W1), .WINDOW(WIN1)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_sig_in(sig1), .o_level(lvl1),
    .o_cnt_out(cnt1), .o_cnt_valid(val1), .i_cnt_ready(rdy1), .o_overrun(ovr1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "simulation time limit reached");
  end

  // One clock edge of the reference: filtered level follows the input seen
  // two edges ago once the last FILT such samples all differ from it.
  task automatic model_edge(input int i, input bit r, input bit sig, input bit rdy);
    int filt, wmax, win, m, snap;
    bit all_diff, v, rise;
    filt = (i == 0) ? F0 : F1;
    wmax = (i == 0) ? (1 << W0) - 1 : (1 << W1) - 1;
    win  = (i == 0) ? WIN0 : WIN1;
    if (r) begin
      m_n[i] = 0; m_lvl[i] = 1'b0; m_rises[i] = 0;
      m_pend[i] = 1'b0; m_val[i] = 0; m_ovr[i] = 1'b0;
    end else begin
      raw_h[i][m_n[i] % 64] = sig;
      all_diff = 1'b1;
      for (int k = 0; k < filt; k++) begin
        m = m_n[i] - 2 - k;
        v = (m >= 0) ? raw_h[i][m % 64] : 1'b0;
        if (v == m_lvl[i]) all_diff = 1'b0;
      end
      rise = all_diff && !m_lvl[i];
      if (all_diff) m_lvl[i] = !m_lvl[i];
      if (rise) m_rises[i]++;
      if (m_n[i] % win == win - 1) begin
        snap = (m_rises[i] > wmax) ? wmax : m_rises[i];
        m_rises[i] = 0;
        if (!m_pend[i]) begin
          m_val[i] = snap; m_pend[i] = 1'b1;
        end else if (rdy) begin
          m_val[i] = snap;
        end else begin
          m_ovr[i] = 1'b1;
        end
      end else if (m_pend[i] && rdy) begin
        m_pend[i] = 1'b0;
      end
      m_n[i]++;
    end
  endtask

  // Advance one cycle: inputs were set at the falling edge, the model takes
  // the rising edge, and the bench returns at the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge(0, rst, sig0, rdy0);
    model_edge(1, rst, sig1, rdy1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; sig0 = 1'b0; sig1 = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulses0(input int n, input int hi, input int lo);
    for (int p = 0; p < n; p++) begin
      sig0 = 1'b1; repeat (hi) tick();
      sig0 = 1'b0; repeat (lo) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) rst = 1'b0;
      sig0 = c[0]; sig1 = ~c[0];
      tick();
      total++; if (lvl0 !== 1'b0) begin bad++; $display("FAIL reset_level c=%0d: got %b want 0", c, lvl0); end
      total++; if (cnt0 !== 8'd0) begin bad++; $display("FAIL reset_cnt c=%0d: got %0d want 0", c, cnt0); end
      total++; if (val0 !== 1'b0) begin bad++; $display("FAIL reset_valid c=%0d: got %b want 0", c, val0); end
      total++; if (ovr0 !== 1'b0) begin bad++; $display("FAIL reset_overrun c=%0d: got %b want 0", c, ovr0); end
    end
  endtask

  task automatic test_glitch();
    do_reset(); rdy0 = 1'b1;
    sig0 = 1'b1; tick(); tick(); sig0 = 1'b0;
    for (int g = 0; g < 5; g++) begin
      repeat ($urandom_range(3, 8)) tick();
      sig0 = 1'b1;
      repeat ($urandom_range(1, F0 - 1)) tick();
      sig0 = 1'b0;
      total++; if (lvl0 !== 1'b0) begin bad++; $display("FAIL glitch_level g=%0d: got %b want 0", g, lvl0); end
    end
    while (m_n[0] < WIN0) begin
      tick();
      total++; if (lvl0 !== 1'b0) begin bad++; $display("FAIL glitch_level n=%0d: got %b want 0", m_n[0], lvl0); end
    end
    total++; if (val0 !== 1'b1) begin bad++; $display("FAIL glitch_valid: got %b want 1", val0); end
    total++; if (cnt0 !== 8'd0) begin bad++; $display("FAIL glitch_cnt: got %0d want 0", cnt0); end
  endtask

  task automatic test_count();
    bit exp;
    do_reset(); rdy0 = 1'b1;
    repeat (10) tick();
    for (int p = 0; p < 5; p++) begin
      sig0 = 1'b1;
      for (int t = 1; t <= 8; t++) begin
        if (t == 5) sig0 = 1'b0;
        tick();
        exp = (t >= 5);
        total++; if (lvl0 !== exp) begin bad++; $display("FAIL count_level p=%0d t=%0d: got %b want %b", p, t, lvl0, exp); end
      end
    end
    while (m_n[0] < WIN0) begin
      total++; if (val0 !== 1'b0) begin bad++; $display("FAIL count_early_valid n=%0d: got %b want 0", m_n[0], val0); end
      tick();
    end
    total++; if (val0 !== 1'b1) begin bad++; $display("FAIL count_valid: got %b want 1", val0); end
    total++; if (cnt0 !== 8'd5) begin bad++; $display("FAIL count_value: got %0d want 5", cnt0); end
  endtask

  task automatic test_saturate();
    do_reset(); rdy1 = 1'b1;
    for (int p = 0; p < 20; p++) begin
      sig1 = 1'b1; tick(); tick();
      sig1 = 1'b0; tick(); tick();
    end
    while (m_n[1] < WIN1) tick();
    total++; if (val1 !== 1'b1) begin bad++; $display("FAIL sat_valid: got %b want 1", val1); end
    total++; if (cnt1 !== 4'd15) begin bad++; $display("FAIL sat_value: got %0d want 15", cnt1); end
    while (m_n[1] < 2 * WIN1) tick();
    total++; if (val1 !== 1'b1) begin bad++; $display("FAIL sat_empty_valid: got %b want 1", val1); end
    total++; if (cnt1 !== 4'd0) begin bad++; $display("FAIL sat_empty_value: got %0d want 0", cnt1); end
  endtask

  task automatic test_overrun();
    do_reset(); rdy0 = 1'b0;
    pulses0(3, 4, 4);
    while (m_n[0] < WIN0) tick();
    total++; if (cnt0 !== 8'd3) begin bad++; $display("FAIL ovr_first_cnt: got %0d want 3", cnt0); end
    total++; if (ovr0 !== 1'b0) begin bad++; $display("FAIL ovr_first_flag: got %b want 0", ovr0); end
    pulses0(7, 4, 4);
    while (m_n[0] < 2 * WIN0) tick();
    total++; if (cnt0 !== 8'd3) begin bad++; $display("FAIL ovr_kept_cnt: got %0d want 3", cnt0); end
    total++; if (ovr0 !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", ovr0); end
    total++; if (val0 !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", val0); end
    rdy0 = 1'b1; tick(); rdy0 = 1'b0;
    total++; if (val0 !== 1'b0) begin bad++; $display("FAIL ovr_accept_valid: got %b want 0", val0); end
    tick();
    total++; if (ovr0 !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", ovr0); end
    total++; if (cnt0 !== 8'd3) begin bad++; $display("FAIL ovr_last_cnt: got %0d want 3", cnt0); end
  endtask

  task automatic test_back_to_back();
    do_reset(); rdy0 = 1'b0;
    pulses0(2, 4, 4);
    while (m_n[0] < WIN0) tick();
    pulses0(4, 4, 4);
    while (m_n[0] < 2 * WIN0 - 1) tick();
    rdy0 = 1'b1; tick(); rdy0 = 1'b0;
    total++; if (cnt0 !== 8'd4) begin bad++; $display("FAIL b2b_cnt: got %0d want 4", cnt0); end
    total++; if (val0 !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b want 1", val0); end
    total++; if (ovr0 !== 1'b0) begin bad++; $display("FAIL b2b_overrun: got %b want 0", ovr0); end
  endtask

  task automatic test_midreset();
    do_reset(); rdy0 = 1'b1;
    pulses0(4, 4, 4);
    while (m_n[0] < 50) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (lvl0 !== 1'b0) begin bad++; $display("FAIL mid_reset_level: got %b want 0", lvl0); end
    while (m_n[0] < WIN0) begin
      total++; if (val0 !== 1'b0) begin bad++; $display("FAIL mid_early_valid n=%0d: got %b want 0", m_n[0], val0); end
      tick();
    end
    total++; if (val0 !== 1'b1) begin bad++; $display("FAIL mid_valid: got %b want 1", val0); end
    total++; if (cnt0 !== 8'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", cnt0); end
  endtask

  task automatic test_random();
    int run0, run1;
    do_reset();
    run0 = 0; run1 = 0;
    for (int c = 0; c < 600; c++) begin
      if (run0 == 0) begin sig0 = ~sig0; run0 = $urandom_range(1, 7); end
      if (run1 == 0) begin sig1 = ~sig1; run1 = $urandom_range(1, 4); end
      run0--; run1--;
      rdy0 = ($urandom_range(0, 3) == 0);
      rdy1 = ($urandom_range(0, 2) == 0);
      tick();
      total++; if (lvl0 !== m_lvl[0]) begin bad++; $display("FAIL rnd_level0 c=%0d: got %b want %b", c, lvl0, m_lvl[0]); end
      total++; if (val0 !== m_pend[0]) begin bad++; $display("FAIL rnd_valid0 c=%0d: got %b want %b", c, val0, m_pend[0]); end
      total++; if (cnt0 !== m_val[0][7:0]) begin bad++; $display("FAIL rnd_cnt0 c=%0d: got %0d want %0d", c, cnt0, m_val[0]); end
      total++; if (ovr0 !== m_ovr[0]) begin bad++; $display("FAIL rnd_ovr0 c=%0d: got %b want %b", c, ovr0, m_ovr[0]); end
      total++; if (lvl1 !== m_lvl[1]) begin bad++; $display("FAIL rnd_level1 c=%0d: got %b want %b", c, lvl1, m_lvl[1]); end
      total++; if (val1 !== m_pend[1]) begin bad++; $display("FAIL rnd_valid1 c=%0d: got %b want %b", c, val1, m_pend[1]); end
      total++; if (cnt1 !== m_val[1][3:0]) begin bad++; $display("FAIL rnd_cnt1 c=%0d: got %0d want %0d", c, cnt1, m_val[1]); end
      total++; if (ovr1 !== m_ovr[1]) begin bad++; $display("FAIL rnd_ovr1 c=%0d: got %b want %b", c, ovr1, m_ovr[1]); end
    end
  endtask

  initial begin
    rst = 1'b1; sig0 = 1'b0; sig1 = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_glitch();
    test_count();
    test_saturate();
    test_overrun();
    test_back_to_back();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_event_counter.md
Name: pulse_event_counter

Overview:
- Downstream consumer of the T-flip-flop pulse generator output `o`. That signal is asynchronous to this clock and can glitch.
- Synchronises the input, then rejects glitches shorter than FILT cycles.
- Counts clean rising edges over a fixed window of WINDOW clock cycles.
- Hands each window's count to the next stage over a valid/ready handshake, with sticky overrun reporting.

Parameters:
- FILT, 3, consecutive synchronised samples that must differ from the current filtered level before it changes (legal 1..15).
- WIDTH, 8, width of the event counter and output count.
- WINDOW, 100, window length in clk cycles (legal >= 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- sig_in  input  1  raw pulse signal (generator output `o`); asynchronous, may glitch.
- level  output  1  filtered, synchronised level of sig_in.
- cnt_out  output  WIDTH  count of rising edges in the last completed window.
- cnt_valid  output  1  cnt_out holds an untransferred snapshot.
- cnt_ready  input  1  consumer accepts cnt_out.
- overrun  output  1  sticky: a window snapshot was dropped.

Behaviour:
- Reset (rst=1 at clk edge):
  - sync flops s1 and s2 = 0; level = 0; filter counter = 0.
  - window counter wcnt = 0; accumulator acc = 0.
  - cnt_out = 0, cnt_valid = 0, overrun = 0; FSM = IDLE.
  - Reset asserted mid-window discards the partial count and any pending snapshot.
- Synchroniser: s1 <= sig_in; s2 <= s1. This gives 2 cycles of latency. Only s2 is used downstream.
- Glitch filter:
  - While s2 == level, the filter counter fc <= 0.
  - While s2 != level, fc increments.
  - On the edge where s2 has differed for FILT consecutive edges (this edge included), level <= s2 and fc <= 0.
  - Total latency from a clean sig_in change to level: 2 + FILT cycles.
  - A high pulse on s2 shorter than FILT cycles never reaches level.
- Edge detect: rise = 1 in the cycle in which level will go 0->1 (level_next & ~level). Each clean pulse counts exactly once.
- Accumulator:
  - acc increments on rise.
  - acc saturates at 2^WIDTH-1 and never wraps.
- Window timer:
  - wcnt counts 0..WINDOW-1 and wraps to 0.
  - win_end = (wcnt == WINDOW-1).
  - The first window ends WINDOW cycles after reset deassertion.
- On win_end:
  - snapshot = sat(acc + rise), so a rise in the last cycle belongs to the closing window.
  - acc <= 0.
- Output FSM (states IDLE, HOLD):
  - IDLE: cnt_valid = 0. On win_end: cnt_out <= snapshot, go to HOLD.
  - HOLD: cnt_valid = 1; cnt_out stays stable until the transfer.
    - cnt_ready=1 and no win_end: transfer completes, go to IDLE; cnt_valid falls the next cycle; cnt_out keeps its last value.
    - cnt_ready=1 and win_end in the same cycle: transfer completes, cnt_out <= new snapshot, stay in HOLD, no overrun.
    - cnt_ready=0 and win_end: the new snapshot is dropped, cnt_out is unchanged, overrun <= 1.
  - overrun clears only on rst.
- cnt_ready while in IDLE is ignored.
- All outputs are registered.

Decomposition:
- Package pulse_cnt_pkg:
  - typedef enum logic {IDLE, HOLD} out_state_t.
  - Default constants FILT_DEF=3, WIDTH_DEF=8, WINDOW_DEF=100.
  - Function sat_inc(value, inc, width) for the saturating add.
- Sub-module glitch_filter (parameter FILT; ports clk, rst, d_async, level):
  - contains the 2-flop synchroniser, fc and level.
  - Reusable for other asynchronous inputs.
- Top level holds edge detect, acc, wcnt and the output FSM.

Test Plan:
1. rst=1 for 2 cycles with sig_in toggling -> level=0, cnt_out=0, cnt_valid=0, overrun=0 throughout reset and the first cycle after it.
2. FILT=3, sig_in high for 2 cycles then low, cnt_ready=1 -> level stays 0; at the end of window 1, cnt_valid=1 with cnt_out=0.
3. FILT=3, WINDOW=100, 5 pulses (4 high / 4 low) starting at cycle 10 after reset, cnt_ready=1 -> cnt_valid=1 in the cycle after wcnt=99 with cnt_out=5; level rises 5 cycles after each sig_in rise.
4. WIDTH=4, 20 clean pulses in one window -> cnt_out=15 (saturated, no wrap); the next empty window reports 0.
5. cnt_ready=0 across two window ends with 3 then 7 pulses -> cnt_out stays 3 and overrun=1 after the second end; then cnt_ready=1 for 1 cycle -> cnt_valid=0 next cycle, overrun stays 1.
6. Two timed cases:
   - cnt_ready=1 exactly in a win_end cycle while in HOLD -> cnt_out updates to the new count, cnt_valid stays 1, overrun=0.
   - rst pulsed at wcnt=50 after 4 pulses -> the next snapshot (WINDOW cycles later, no pulses) reports 0.
